// File: rtl/ones_pkg.sv
// Shared types and width helpers for the ones-counting frame accumulator.
package ones_pkg;

    typedef enum logic [0:0] {
        EMPTY  = 1'b0,
        ACTIVE = 1'b1
    } frame_state_e;

    // Bits needed to hold any value in 0..max_val.
    function automatic int width_for(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/popcount_comb.sv
// Combinational count of the 1 bits in one input word.
module popcount_comb #(
    parameter int DATA_WIDTH = 16,
    parameter int CW         = $clog2(DATA_WIDTH) + 1
) (
    input  logic [DATA_WIDTH-1:0] din,
    output logic [CW-1:0]         count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            count = count + CW'(din[i]);
        end
    end

endmodule

// File: rtl/ones_frame_accumulator.sv
// Accumulates per-word ones counts over a din_last-delimited frame and
// presents one registered total per frame under valid/ready.
module ones_frame_accumulator
    import ones_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_WORDS  = 256,
    parameter int TW         = width_for(DATA_WIDTH * MAX_WORDS),
    parameter int WW         = width_for(MAX_WORDS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_last,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [TW-1:0]         dout,
    output logic [WW-1:0]         dout_words,
    output logic                  dout_ovf,
    output frame_state_e          dbg_state
);

    // Handshake: a transfer happens on a port in any cycle where valid and
    // ready are both high at the rising edge; valid never waits on ready.
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [WW-1:0] MAX_W = WW'(MAX_WORDS);

    frame_state_e    r_state;
    frame_state_e    w_state_next;
    logic [TW-1:0]   r_acc;
    logic [WW-1:0]   r_words;
    logic            r_ovf;
    logic [TW-1:0]   r_dout;
    logic [WW-1:0]   r_dout_words;
    logic            r_dout_ovf;
    logic            r_dout_valid;

    logic [CW-1:0]   w_cnt;
    logic            w_accept;
    logic            w_room;
    logic [TW-1:0]   w_acc_next;
    logic [WW-1:0]   w_words_next;
    logic            w_ovf_next;

    popcount_comb #(
        .DATA_WIDTH(DATA_WIDTH),
        .CW        (CW)
    ) u_popcount (
        .din  (din),
        .count(w_cnt)
    );

    assign din_ready    = !r_dout_valid || dout_ready;
    assign w_accept     = din_valid && din_ready;
    assign w_room       = r_words < MAX_W;
    // Words past the cap are accepted but contribute nothing except ovf.
    assign w_acc_next   = w_room ? r_acc + {{(TW-CW){1'b0}}, w_cnt} : r_acc;
    assign w_words_next = w_room ? r_words + WW'(1) : r_words;
    assign w_ovf_next   = r_ovf || !w_room;

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = din_last ? EMPTY : ACTIVE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc   <= '0;
            r_words <= '0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            if (din_last) begin
                r_acc   <= '0;
                r_words <= '0;
                r_ovf   <= 1'b0;
            end else begin
                r_acc   <= w_acc_next;
                r_words <= w_words_next;
                r_ovf   <= w_ovf_next;
            end
        end
    end

    // A reload in the same cycle as consumption keeps dout_valid high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dout       <= '0;
            r_dout_words <= '0;
            r_dout_ovf   <= 1'b0;
            r_dout_valid <= 1'b0;
        end else if (w_accept && din_last) begin
            r_dout       <= w_acc_next;
            r_dout_words <= w_words_next;
            r_dout_ovf   <= w_ovf_next;
            r_dout_valid <= 1'b1;
        end else if (dout_ready) begin
            r_dout_valid <= 1'b0;
        end
    end

    assign dout_valid = r_dout_valid;
    assign dout       = r_dout;
    assign dout_words = r_dout_words;
    assign dout_ovf   = r_dout_ovf;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_ones_frame_accumulator.sv
// Directed bench for ones_frame_accumulator (DATA_WIDTH=16, MAX_WORDS=4).
module tb_ones_frame_accumulator;
    import ones_pkg::*;

    localparam int DATA_WIDTH = 16;
    localparam int MAX_WORDS  = 4;
    localparam int TW         = 7;
    localparam int WW         = 3;

    logic                  clk;
    logic                  reset;
    logic                  din_valid;
    logic                  din_ready;
    logic [DATA_WIDTH-1:0] din;
    logic                  din_last;
    logic                  dout_valid;
    logic                  dout_ready;
    logic [TW-1:0]         dout;
    logic [WW-1:0]         dout_words;
    logic                  dout_ovf;
    frame_state_e          dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    ones_frame_accumulator #(
        .DATA_WIDTH(DATA_WIDTH),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .din       (din),
        .din_last  (din_last),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout      (dout),
        .dout_words(dout_words),
        .dout_ovf  (dout_ovf),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change only here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [DATA_WIDTH-1:0] d, input logic last);
        din_valid = 1'b1;
        din       = d;
        din_last  = last;
    endtask

    task automatic idle();
        din_valid = 1'b0;
        din       = '0;
        din_last  = 1'b0;
    endtask

    task automatic check_result(input string tag, input int t, input int w, input int o);
        check({tag, "_valid"}, 32'(dout_valid), 32'd1);
        check({tag, "_dout"},  32'(dout),       32'(t));
        check({tag, "_words"}, 32'(dout_words), 32'(w));
        check({tag, "_ovf"},   32'(dout_ovf),   32'(o));
    endtask

    initial begin
        reset      = 1'b1;
        dout_ready = 1'b1;
        idle();
        step();
        step();
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_dout",  32'(dout),       32'd0);
        check("rst_words", 32'(dout_words), 32'd0);
        check("rst_ovf",   32'(dout_ovf),   32'd0);
        check("rst_ready", 32'(din_ready),  32'd1);
        check("rst_state", 32'(dbg_state),  32'(EMPTY));
        reset = 1'b0;
        step();

        // 1: three-word frame, total 8+8+1
        drive(16'h00FF, 1'b0);
        step();
        check("t1_state_active", 32'(dbg_state), 32'(ACTIVE));
        drive(16'hF0F0, 1'b0);
        step();
        check("t1_no_early_valid", 32'(dout_valid), 32'd0);
        drive(16'h0001, 1'b1);
        step();
        check_result("t1", 17, 3, 0);
        check("t1_state_empty", 32'(dbg_state), 32'(EMPTY));
        idle();
        step();
        check("t1_valid_drop", 32'(dout_valid), 32'd0);

        // 2: back-to-back single-word frames
        drive(16'hFFFF, 1'b1);
        step();
        check_result("t2a", 16, 1, 0);
        drive(16'h0000, 1'b1);
        step();
        check_result("t2b", 0, 1, 0);
        idle();
        step();
        check("t2_valid_drop", 32'(dout_valid), 32'd0);

        // 3: backpressure freezes the stage until dout_ready rises
        dout_ready = 1'b0;
        drive(16'h000F, 1'b1);
        step();
        check_result("t3", 4, 1, 0);
        drive(16'h0002, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("t3_din_ready_low", 32'(din_ready), 32'd0);
            check("t3_hold_dout", 32'(dout), 32'd4);
            step();
        end
        dout_ready = 1'b1;
        #1;
        check("t3_din_ready_high", 32'(din_ready), 32'd1);
        step();
        check_result("t3_next", 1, 1, 0);
        idle();
        step();

        // 4: five words of 0xFFFF overflow the 4-word cap
        for (int i = 0; i < 4; i++) begin
            drive(16'hFFFF, 1'b0);
            step();
        end
        drive(16'hFFFF, 1'b1);
        step();
        check_result("t4_ovf", 64, 4, 1);
        drive(16'h0001, 1'b1);
        step();
        check_result("t4_after", 1, 1, 0);
        idle();
        step();

        // 5: asynchronous reset mid-frame discards the partial frame
        drive(16'hFFFF, 1'b0);
        step();
        drive(16'hFFFF, 1'b0);
        step();
        idle();
        #2;
        reset = 1'b1;
        #1;
        check("t5_rst_valid", 32'(dout_valid), 32'd0);
        check("t5_rst_dout",  32'(dout),       32'd0);
        check("t5_rst_words", 32'(dout_words), 32'd0);
        check("t5_rst_ovf",   32'(dout_ovf),   32'd0);
        check("t5_rst_state", 32'(dbg_state),  32'(EMPTY));
        step();
        reset = 1'b0;
        step();
        drive(16'h0003, 1'b1);
        step();
        check_result("t5", 2, 1, 0);
        idle();
        step();

        // 6: valid gaps inside a frame; din/din_last ignored while idle
        drive(16'h8000, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            din_valid = 1'b0;
            din       = 16'hFFFF;
            din_last  = 1'b1;
            step();
            check("t6_gap_no_valid", 32'(dout_valid), 32'd0);
        end
        drive(16'h8001, 1'b1);
        step();
        check_result("t6", 3, 2, 0);
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
